ssd_char_scanner: RTL
=====================

SSD_CHAR_SCANNER -- requirements
Module: ssd_char_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, meaning clock cycles per digit slot; legal range is at least 2.
REQ-002 SHALL have parameter BLANK_CYCLES, default 2, meaning anode-off cycles at the start of each slot for ghosting suppression; legal range is 0 to REFRESH_DIV-1.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clear  input  1  synchronous buffer clear.
REQ-006 SHALL have port char_valid  input  1  upstream character strobe.
REQ-007 SHALL have port char_data  input  8  upstream ASCII byte.
REQ-008 SHALL have port char_ready  output  1  character accept, equal to NOT clear.
REQ-009 SHALL have port ascii_out  output  8  ASCII of the selected digit, feeding the ASCII-to-SSD decoder.
REQ-010 SHALL have port anode  output  4  active-low digit enables, one-hot low; bit 0 is the rightmost digit.

Function
REQ-011 SHALL hold a 4-entry character buffer buf[3:0], with buf[0] the rightmost digit and buf[3] the leftmost.
REQ-012 SHALL accept a byte on any rising edge where char_valid=1 and char_ready=1; no other handshake state exists.
REQ-013 SHALL, for a printable byte (0x20..0x7E), shift left: buf[3]<=buf[2], buf[2]<=buf[1], buf[1]<=buf[0], buf[0]<=char_data (scroll in from the right).
REQ-014 SHALL, for 0x08 (backspace), shift right: buf[0]<=buf[1], buf[1]<=buf[2], buf[2]<=buf[3], buf[3]<=0x20.
REQ-015 SHALL, for 0x0D or 0x0A, load all entries with 0x20.
REQ-016 SHALL accept and discard every other byte (0x00..0x1F except 0x08/0x0A/0x0D, and 0x7F..0xFF), leaving the buffer unchanged.
REQ-017 SHALL store case unchanged; case folding is the decoder's job.
REQ-018 SHALL, when clear=1, load all entries with 0x20 on that edge; char_ready=0 in the same cycle, so a simultaneous char_valid byte is neither accepted nor stored.
REQ-019 SHALL run slot counter cnt from 0 to REFRESH_DIV-1 and wrap to 0; on the wrap edge, digit index idx (2 bits) increments 0,1,2,3,0.
REQ-020 SHALL drive anode=4'b1111 while cnt < BLANK_CYCLES, otherwise anode = ~(4'b0001 << idx).
REQ-021 SHALL drive ascii_out combinationally as buf[idx]; a byte accepted at edge k is visible on ascii_out after edge k whenever its slot is selected (0-cycle buffer-to-output latency).
REQ-022 SHALL keep scanning unaffected by accepts, clear, or backspace; cnt and idx are never reset except by rst.
REQ-023 SHALL produce a full frame of 4*REFRESH_DIV cycles; with BLANK_CYCLES=0, anode is never 4'b1111 after reset.

Reset
REQ-024 SHALL, on rst assertion at any time including mid-slot, asynchronously set buf to four 0x20, cnt=0, and idx=0.
REQ-025 SHALL, during reset, output ascii_out=0x20 and char_ready=NOT clear; anode=4'b1111 if BLANK_CYCLES>0, else 4'b1110.
REQ-026 SHALL resume scanning from slot 0, cnt 0, on the first rising edge after rst deasserts.

Verification
REQ-027 SHALL cover scroll: REFRESH_DIV=4, BLANK_CYCLES=1; send "1","2","3","4","5" -> buf[3..0]="2345"; over one frame anode sequence 1111,1110,1110,1110,1111,1101,... with ascii_out 0x35, 0x34, 0x33, 0x32 in slots 0..3.
REQ-028 SHALL cover backspace and line end: from "2345", send 0x08 -> " 234"; then 0x0D -> "    " (all 0x20).
REQ-029 SHALL cover clear collision: clear=1 and char_valid=1 with 0x41 on the same edge -> char_ready=0, buffer all 0x20, 0x41 absent.
REQ-030 SHALL cover ignored bytes: from "ABCD", send 0x07, 0x1B, 0xFF -> buffer stays "ABCD" and char_ready stays 1.
REQ-031 SHALL cover mid-operation reset: assert rst asynchronously mid-slot with idx=2 -> anode=1111, idx=0, cnt=0, and ascii_out=0x20 immediately, before any clock edge.
REQ-032 SHALL cover back-to-back accepts: char_valid held for 6 consecutive cycles with "ABCDEF" -> buffer "CDEF", with each intermediate state checked cycle-by-cycle.

Source files
------------

// File: rtl/ssd_char_scanner.sv
// ssd_char_scanner
//   Four-character scrolling buffer with a multiplexed seven-segment digit
//   scanner. Printable ASCII scrolls in from the right. Backspace scrolls
//   right. CR and LF blank the display. All other bytes are accepted and
//   dropped. The scanner gives each digit REFRESH_DIV clock cycles. Anodes
//   stay off for the first BLANK_CYCLES cycles of each slot to suppress
//   ghosting.
//
// Parameters
//   REFRESH_DIV  : clock cycles per digit slot (>= 2)
//   BLANK_CYCLES : anode-off cycles at the start of each slot (0..REFRESH_DIV-1)
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   clear      : synchronous buffer clear (takes priority over char_valid)
//   char_valid : upstream character strobe
//   char_data  : upstream ASCII byte
//   char_ready : character accept, equal to ~clear
//   ascii_out  : ASCII of the currently selected digit
//   anode      : active-low digit enables, bit 0 = rightmost digit
module ssd_char_scanner #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic [7:0] ascii_out,
  output logic [3:0] anode
);

  localparam int unsigned   CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [7:0]    SPACE    = 8'h20;

  // char_buf[0] is the rightmost digit, char_buf[3] the leftmost
  logic [3:0][7:0] char_buf;
  logic [CW-1:0]   cnt;
  logic [1:0]      idx;
  logic            blank;

  assign char_ready = ~clear;

  // Character buffer. clear wins over char_valid, which matches char_ready
  // being low in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_buf <= {4{SPACE}};
    end else if (clear) begin
      char_buf <= {4{SPACE}};
    end else if (char_valid) begin
      if (char_data >= 8'h20 && char_data <= 8'h7E) begin
        char_buf <= {char_buf[2:0], char_data};
      end else if (char_data == 8'h08) begin
        char_buf <= {SPACE, char_buf[3:1]};
      end else if (char_data == 8'h0D || char_data == 8'h0A) begin
        char_buf <= {4{SPACE}};
      end
    end
  end

  // Slot scanner. It is free running and only rst resets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // With no blanking there is no comparison against zero to build.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign blank = 1'b0;
    end else begin : g_blank
      assign blank = (cnt < CW'(BLANK_CYCLES));
    end
  endgenerate

  assign anode     = blank ? 4'b1111 : ~(4'b0001 << idx);
  assign ascii_out = char_buf[idx];

endmodule
